tm_fetch: RTL and testbench

- Instruction fetch/prefetch stage directly upstream of the SPI read engine (tm_spi_read).
- Generates word fetch requests on the engine's valid/addr/done handshake and captures returned 16-bit words into a small prefetch FIFO.
- Presents instructions to the Turing-machine core on a valid/ready interface; handles core redirects (jumps) with flush and stale-discard.

---
 rtl/tm_pkg.sv | 17 +
 rtl/tm_fetch_fifo.sv | 71 +++++++
 rtl/tm_fetch.sv | 124 ++++++++++++
 tb/tb_tm_fetch.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tm_pkg.sv
// Shared definitions for the Turing-machine fetch path and SPI read engine.
// Holds widths, the SPI read opcode and fetch FSM encodings.
package tm_pkg;

  localparam int TM_PC_W = 15;
  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  localparam logic [7:0] SPI_CMD_READ = 8'h03;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_READ = 2'd1,
    FS_GAP  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/tm_fetch_fifo.sv
// Prefetch FIFO: DEPTH x W, flush wins over push/pop.
// Ports: push/data_i in, pop, flush, count_o, valid_o, head_o out.
module tm_fetch_fifo
  import tm_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = TM_PC_W + INSTR_W,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [CW-1:0] count_o,
  output logic          valid_o,
  output logic [W-1:0]  head_o
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != FULL) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign count_o = count_q;
  assign valid_o = (count_q != '0);
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/tm_fetch.sv
// Instruction prefetch stage feeding the core from the SPI read engine.
// Ports: rd_* engine handshake, redirect_*, instr_* core valid/ready.
module tm_fetch
  import tm_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int PC_W     = TM_PC_W,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            rd_valid_o,
  output logic [15:0]     rd_addr_o,
  input  logic            rd_done_i,
  input  logic [15:0]     rd_data_i,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [15:0]     instr_o,
  output logic [PC_W-1:0] instr_pc_o
);

  localparam int W  = PC_W + INSTR_W;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] fpc_q, fpc_d;
  logic [PC_W-1:0] req_pc_q, req_pc_d;
  logic [15:0]     addr_q, addr_d;
  logic            stale_q, stale_d;

  logic [CW-1:0]   count;
  logic            push;
  logic            room;
  logic [PC_W-1:0] next_pc;
  logic [W-1:0]    head;

  // A redirect flushes the FIFO this cycle, so space is guaranteed and
  // a request launched now must already use the jump target.
  assign room    = redirect_i || (count < FULL);
  assign next_pc = redirect_i ? redirect_pc_i : fpc_q;

  always_comb begin
    state_d  = state_q;
    fpc_d    = fpc_q;
    req_pc_d = req_pc_q;
    addr_d   = addr_q;
    stale_d  = stale_q;
    push     = 1'b0;
    if (redirect_i) fpc_d = redirect_pc_i;
    unique case (state_q)
      FS_IDLE: begin
        if (room) begin
          state_d  = FS_READ;
          req_pc_d = next_pc;
          addr_d   = 16'({next_pc, 1'b0});
        end
      end
      FS_READ: begin
        if (rd_done_i) begin
          if (!stale_q && !redirect_i) begin
            push  = 1'b1;
            fpc_d = req_pc_q + PC_W'(1);
          end
          stale_d = 1'b0;
          state_d = FS_GAP;
        end else if (redirect_i) begin
          // Engine cannot be aborted: keep the request, drop its word.
          stale_d = 1'b1;
        end
      end
      FS_GAP: begin
        if (room) begin
          state_d  = FS_READ;
          req_pc_d = next_pc;
          addr_d   = 16'({next_pc, 1'b0});
        end else begin
          state_d = FS_IDLE;
        end
      end
      default: state_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FS_IDLE;
      fpc_q    <= PC_W'(RESET_PC);
      req_pc_q <= '0;
      addr_q   <= '0;
      stale_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      req_pc_q <= req_pc_d;
      addr_q   <= addr_d;
      stale_q  <= stale_d;
    end
  end

  assign rd_valid_o = (state_q == FS_READ);
  assign rd_addr_o  = addr_q;

  tm_fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  ({req_pc_q, rd_data_i}),
    .pop_i   (instr_valid_o && instr_ready_i),
    .flush_i (redirect_i),
    .count_o (count),
    .valid_o (instr_valid_o),
    .head_o  (head)
  );

  assign instr_o    = head[15:0];
  assign instr_pc_o = head[W-1:16];

endmodule

// File: tb/tb_tm_fetch.sv
// Self-checking bench for tm_fetch with an SPI engine model.
// Scoreboard of expected {pc, word} pushed on engine returns.
module tb_tm_fetch;

  logic        clk;
  logic        rst_n;
  logic        rd_valid_o;
  logic [15:0] rd_addr_o;
  logic        rd_done_i;
  logic [15:0] rd_data_i;
  logic        redirect_i;
  logic [14:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [15:0] instr_o;
  logic [14:0] instr_pc_o;

  int tests;
  int fails;

  logic [15:0] req_q[$];
  int          gap_q[$];
  logic [14:0] seen_q[$];
  logic [30:0] exp_q[$];

  int          lat;
  bit          eng_busy;
  int          eng_cnt;
  logic [15:0] eng_addr;
  int          gap;
  bit          have_prev;
  bit          m_stale;

  tm_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_valid_o    (rd_valid_o),
    .rd_addr_o     (rd_addr_o),
    .rd_done_i     (rd_done_i),
    .rd_data_i     (rd_data_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine model: answers mem[a] = a ^ A5A5 after lat cycles.
  initial begin
    rd_done_i = 1'b0;
    rd_data_i = '0;
    eng_busy  = 0;
    have_prev = 0;
    gap       = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        eng_busy  = 0;
        rd_done_i = 1'b0;
        have_prev = 0;
        gap       = 0;
      end else if (rd_done_i) begin
        rd_done_i = 1'b0;
        gap       = 1;
        tests++;
        if (rd_valid_o !== 1'b0) begin
          fails++;
          $display("FAIL gap_after_done: rd_valid %b want 0", rd_valid_o);
        end
      end else if (eng_busy) begin
        tests++;
        if (rd_valid_o !== 1'b1 || rd_addr_o !== eng_addr) begin
          fails++;
          $display("FAIL req_hold: valid %b addr %h want 1 %h",
                   rd_valid_o, rd_addr_o, eng_addr);
        end
        if (eng_cnt <= 1) begin
          rd_done_i = 1'b1;
          rd_data_i = eng_addr ^ 16'hA5A5;
          eng_busy  = 0;
        end else begin
          eng_cnt--;
        end
      end else if (rd_valid_o) begin
        eng_busy = 1;
        eng_cnt  = lat;
        eng_addr = rd_addr_o;
        req_q.push_back(rd_addr_o);
        if (have_prev) gap_q.push_back(gap);
        have_prev = 1;
      end else begin
        gap++;
      end
    end
  end

  // Scoreboard monitor, sampled after all stimulus has settled.
  initial begin
    m_stale = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        exp_q.delete();
        m_stale = 0;
      end else begin
        tests++;
        if (instr_valid_o !== (exp_q.size() != 0)) begin
          fails++;
          $display("FAIL instr_valid: got %b want %0d",
                   instr_valid_o, exp_q.size() != 0);
        end
        if (instr_valid_o && instr_ready_i && !redirect_i
            && exp_q.size() != 0) begin
          logic [30:0] e;
          e = exp_q.pop_front();
          tests++;
          if ({instr_pc_o, instr_o} !== e) begin
            fails++;
            $display("FAIL instr_data: got %h/%h want %h/%h",
                     instr_pc_o, instr_o, e[30:16], e[15:0]);
          end
          seen_q.push_back(instr_pc_o);
        end
        if (redirect_i) begin
          exp_q.delete();
          if (rd_valid_o && !rd_done_i) m_stale = 1;
        end
        if (rd_done_i) begin
          if (!redirect_i && !m_stale)
            exp_q.push_back({rd_addr_o[15:1], rd_addr_o ^ 16'hA5A5});
          m_stale = 0;
        end
      end
    end
  end

  task automatic wait_req(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if (req_q.size() >= n) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_seen(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if (seen_q.size() >= n) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic apply_reset(input bit rdy);
    @(negedge clk);
    #1;
    rst_n         = 1'b0;
    redirect_i    = 1'b0;
    instr_ready_i = rdy;
    repeat (2) @(negedge clk);
    #1;
    req_q.delete();
    gap_q.delete();
    seen_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n         = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    instr_ready_i = 1'b0;
    lat           = 40;
    #3;
    tests++;
    if ({rd_valid_o, rd_addr_o, instr_valid_o, instr_o, instr_pc_o}
        !== '0) begin
      fails++;
      $display("FAIL reset_outputs: %b %h %b %h %h want all 0",
               rd_valid_o, rd_addr_o, instr_valid_o, instr_o, instr_pc_o);
    end
  endtask

  task automatic test_stream;
    bit ok;
    lat = 40;
    apply_reset(1'b1);
    wait_req(3, ok);
    wait_seen(3, ok);
    tests++;
    if (!ok || req_q.size() < 3 || seen_q.size() < 3) begin
      fails++;
      $display("FAIL stream_timeout: req %0d seen %0d want 3",
               req_q.size(), seen_q.size());
    end else begin
      tests++;
      if (req_q[0] !== 16'h0000 || req_q[1] !== 16'h0002
          || req_q[2] !== 16'h0004) begin
        fails++;
        $display("FAIL stream_addr: %h %h %h want 0000 0002 0004",
                 req_q[0], req_q[1], req_q[2]);
      end
      tests++;
      if (seen_q[0] !== 15'd0 || seen_q[1] !== 15'd1
          || seen_q[2] !== 15'd2) begin
        fails++;
        $display("FAIL stream_pc: %h %h %h want 0 1 2",
                 seen_q[0], seen_q[1], seen_q[2]);
      end
      tests++;
      if (gap_q.size() < 2 || gap_q[0] != 1 || gap_q[1] != 1) begin
        fails++;
        $display("FAIL stream_gap: n %0d want gaps of 1", gap_q.size());
      end
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    bit bad;
    lat = 8;
    apply_reset(1'b0);
    wait_req(2, ok);
    repeat (20) @(negedge clk);
    #1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (rd_valid_o) bad = 1;
    end
    tests++;
    if (!ok || bad || req_q.size() != 2) begin
      fails++;
      $display("FAIL bp_stall: ok %0d bad %0d reqs %0d want 1 0 2",
               ok, bad, req_q.size());
    end
    instr_ready_i = 1'b1;
    @(negedge clk);
    #1;
    instr_ready_i = 1'b0;
    tests++;
    if (seen_q.size() != 1 || instr_pc_o !== 15'd1) begin
      fails++;
      $display("FAIL bp_pop: seen %0d head %h want 1 0001",
               seen_q.size(), instr_pc_o);
    end
    wait_req(3, ok);
    tests++;
    if (!ok || req_q[2] !== 16'h0004) begin
      fails++;
      $display("FAIL bp_next_addr: ok %0d want 0004", ok);
    end
  endtask

  task automatic test_redirect_stale;
    bit ok;
    int n;
    lat = 40;
    apply_reset(1'b1);
    wait_req(2, ok);
    repeat (5) @(negedge clk);
    #1;
    tests++;
    if (!ok || !rd_valid_o || rd_addr_o !== 16'h0002) begin
      fails++;
      $display("FAIL stale_pre: valid %b addr %h want 1 0002",
               rd_valid_o, rd_addr_o);
    end
    n             = seen_q.size();
    redirect_i    = 1'b1;
    redirect_pc_i = 15'h0100;
    @(negedge clk);
    #1;
    redirect_i = 1'b0;
    tests++;
    if (rd_valid_o !== 1'b1 || rd_addr_o !== 16'h0002) begin
      fails++;
      $display("FAIL stale_hold: valid %b addr %h want 1 0002",
               rd_valid_o, rd_addr_o);
    end
    wait_req(3, ok);
    tests++;
    if (!ok || req_q[2] !== 16'h0200) begin
      fails++;
      $display("FAIL stale_next_addr: ok %0d want 0200", ok);
    end
    wait_seen(n + 1, ok);
    tests++;
    if (!ok || seen_q[n] !== 15'h0100) begin
      fails++;
      $display("FAIL stale_first_pc: ok %0d want 0100", ok);
    end
  endtask

  task automatic test_redirect_done;
    bit ok;
    bit hit;
    lat = 8;
    apply_reset(1'b0);
    wait_req(2, ok);
    hit = 0;
    for (int i = 0; i < 100; i++) begin
      if (rd_done_i) begin
        hit = 1;
        break;
      end
      @(negedge clk);
      #1;
    end
    tests++;
    if (!hit || !instr_valid_o || rd_addr_o !== 16'h0002) begin
      fails++;
      $display("FAIL rdone_pre: hit %0d valid %b addr %h want 1 1 0002",
               hit, instr_valid_o, rd_addr_o);
    end
    redirect_i    = 1'b1;
    redirect_pc_i = 15'h0123;
    instr_ready_i = 1'b1;
    @(negedge clk);
    #1;
    redirect_i    = 1'b0;
    instr_ready_i = 1'b0;
    tests++;
    if (instr_valid_o !== 1'b0 || seen_q.size() != 0) begin
      fails++;
      $display("FAIL rdone_flush: valid %b seen %0d want 0 0",
               instr_valid_o, seen_q.size());
    end
    instr_ready_i = 1'b1;
    wait_req(3, ok);
    tests++;
    if (!ok || req_q[2] !== 16'h0246) begin
      fails++;
      $display("FAIL rdone_next_addr: ok %0d want 0246", ok);
    end
    wait_seen(1, ok);
    tests++;
    if (!ok || seen_q[0] !== 15'h0123) begin
      fails++;
      $display("FAIL rdone_first_pc: ok %0d want 0123", ok);
    end
  endtask

  task automatic test_wrap;
    bit ok;
    int n;
    int s;
    lat = 8;
    apply_reset(1'b1);
    repeat (3) @(negedge clk);
    #1;
    n             = req_q.size();
    s             = seen_q.size();
    redirect_i    = 1'b1;
    redirect_pc_i = 15'h7FFF;
    @(negedge clk);
    #1;
    redirect_i = 1'b0;
    wait_req(n + 2, ok);
    tests++;
    if (!ok || req_q[n] !== 16'hFFFE || req_q[n+1] !== 16'h0000) begin
      fails++;
      $display("FAIL wrap_addr: ok %0d want FFFE then 0000", ok);
    end
    wait_seen(s + 2, ok);
    tests++;
    if (!ok || seen_q[s] !== 15'h7FFF || seen_q[s+1] !== 15'h0000) begin
      fails++;
      $display("FAIL wrap_pc: ok %0d want 7FFF then 0000", ok);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    lat = 20;
    apply_reset(1'b0);
    wait_req(2, ok);
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (!ok || !rd_valid_o || !instr_valid_o) begin
      fails++;
      $display("FAIL rstmid_pre: valid %b instr %b want 1 1",
               rd_valid_o, instr_valid_o);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (rd_valid_o !== 1'b0 || instr_valid_o !== 1'b0
        || rd_addr_o !== 16'h0000) begin
      fails++;
      $display("FAIL rstmid_async: %b %b %h want 0 0 0000",
               rd_valid_o, instr_valid_o, rd_addr_o);
    end
    @(negedge clk);
    #1;
    req_q.delete();
    gap_q.delete();
    seen_q.delete();
    rst_n = 1'b1;
    wait_req(1, ok);
    tests++;
    if (!ok || req_q[0] !== 16'h0000) begin
      fails++;
      $display("FAIL rstmid_restart: ok %0d want 0000", ok);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_stale();
    test_redirect_done();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
